regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 32×32 register file. It arbitrates the file's single write port between the ALU and load/store unit (LSU) write-back streams and drives a registered write port into the register file. It also keeps a per-register scoreboard of outstanding loads and raises a combinational hazard flag for the decode stage's two source operands. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_scheduler_pkg.sv | 22 ++
 rtl/regfile_wb_scheduler_if.sv | 50 +++++
 rtl/regfile_wb_scheduler_scoreboard.sv | 46 ++++
 rtl/regfile_wb_scheduler.sv | 112 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants, grant-select enum and helpers for the register file write-back scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_sched_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU
    } wb_src_t;

    // x0 is hardwired: a write-back targeting it completes but never writes.
    function automatic logic writes_rf(input logic [AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the ALU/LSU write-back handshakes, load reservation, decode lookup and RF write port.
// Latency: n/a (wiring only).
// Backpressure: alu_ready/lsu_ready are driven by the scheduler (slave modport).
// Ports: alu_* / lsu_* valid-ready write-back streams, lsu_reserve*, rs0/rs1 -> hazard,
//        rf_we/rf_waddr/rf_wdata registered write port.
interface regfile_wb_scheduler_if;
    import regfile_sched_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            lsu_reserve;
    logic [AW-1:0]   lsu_reserve_rd;

    logic [AW-1:0]   rs0;
    logic [AW-1:0]   rs1;
    logic            hazard;

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    // Scheduler side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  lsu_reserve, lsu_reserve_rd,
        input  rs0, rs1,
        output alu_ready, lsu_ready, hazard,
        output rf_we, rf_waddr, rf_wdata
    );

    // Pipeline / register-file side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output lsu_reserve, lsu_reserve_rd,
        output rs0, rs1,
        input  alu_ready, lsu_ready, hazard,
        input  rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Per-register pending-load scoreboard with a two-port combinational hazard lookup.
// Latency: set/clear visible on hazard the cycle after they are presented.
// Backpressure: none; always accepts set and clear.
// Ports: clk, rst (async active-low), set_vld/set_rd (load issued), clr_vld/clr_rd (load written back),
//        rs0/rs1 (decode sources), hazard.
module regfile_scoreboard
    import regfile_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_vld,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_vld,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] rs0,
    input  logic [AW-1:0] rs1,
    output logic          hazard
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Clear first, then set, so a new reservation landing on the register being
    // written back in the same cycle stays pending (it belongs to a younger load).
    always_comb begin
        pending_nxt = pending;
        if (clr_vld) begin
            pending_nxt[clr_rd] = 1'b0;
        end
        if (set_vld) begin
            pending_nxt[set_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign hazard = pending[rs0] | pending[rs1];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and LSU write-back and tracks pending loads.
// Latency: a transfer in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1.
// Backpressure: LSU wins by default; ready is combinational. With REGFILE_STARVE_GUARD_EN defined, an ALU
//   stalled STARVE_MAX cycles is forced through and lsu_ready drops; undefined gives strict LSU priority.
// Ports: clk, rst (async active-low), wb (regfile_wb_scheduler_if.slave).
module regfile_wb_scheduler #(
    parameter int STARVE_MAX = 3
) (
    input logic                   clk,
    input logic                   rst,
    regfile_wb_scheduler_if.slave wb
);
    import regfile_sched_pkg::*;

    if (STARVE_MAX < 1) begin : g_param_check
        $error("regfile_wb_scheduler: STARVE_MAX must be at least 1");
    end

    logic    forced;
    logic    alu_rdy;
    logic    lsu_rdy;
    wb_src_t grant;

`ifdef REGFILE_STARVE_GUARD_EN
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    assign forced = wb.alu_valid && (starve_cnt == STARVE_LIM);

    // Counts consecutive cycles the ALU was left waiting; any gap in alu_valid
    // or a successful ALU transfer starts the count over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!wb.alu_valid || grant == SRC_ALU) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign forced = 1'b0;
`endif

    // Readies are held low during reset so nothing is consumed while the
    // output register and scoreboard are being cleared.
    always_comb begin
        alu_rdy = 1'b0;
        lsu_rdy = 1'b0;
        grant   = SRC_NONE;
        if (rst) begin
            lsu_rdy = !forced;
            alu_rdy = !wb.lsu_valid || forced;
        end
        if (wb.lsu_valid && lsu_rdy) begin
            grant = SRC_LSU;
        end else if (wb.alu_valid && alu_rdy) begin
            grant = SRC_ALU;
        end
    end

    assign wb.alu_ready = alu_rdy;
    assign wb.lsu_ready = lsu_rdy;

    logic            rf_we_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    // Address/data only move on a transfer; the enable alone says whether the
    // register file should capture them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            case (grant)
                SRC_ALU: begin
                    rf_we_q    <= writes_rf(wb.alu_rd);
                    rf_waddr_q <= wb.alu_rd;
                    rf_wdata_q <= wb.alu_data;
                end
                SRC_LSU: begin
                    rf_we_q    <= writes_rf(wb.lsu_rd);
                    rf_waddr_q <= wb.lsu_rd;
                    rf_wdata_q <= wb.lsu_data;
                end
                default: ;
            endcase
        end
    end

    assign wb.rf_we    = rf_we_q;
    assign wb.rf_waddr = rf_waddr_q;
    assign wb.rf_wdata = rf_wdata_q;

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_vld (wb.lsu_reserve),
        .set_rd  (wb.lsu_reserve_rd),
        .clr_vld (grant == SRC_LSU),
        .clr_rd  (wb.lsu_rd),
        .rs0     (wb.rs0),
        .rs1     (wb.rs1),
        .hazard  (wb.hazard)
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios with literal expectations, then random traffic,
// all checked every negedge against a rule-level model (set of pending registers, stall run length).
module tb_regfile_wb_scheduler;
    import regfile_sched_pkg::*;

    localparam int SMAX = 3;
`ifdef REGFILE_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if wb();

    regfile_wb_scheduler #(.STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          pend[int];      // registers with an outstanding load
    int          stalled_run;    // consecutive cycles the ALU has waited
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            stalled_run = 0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            chk("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
            chk("rst_lsu_ready", 32'(wb.lsu_ready), 32'd0);
            chk("rst_rf_we",     32'(wb.rf_we),     32'd0);
            chk("rst_rf_waddr",  32'(wb.rf_waddr),  32'd0);
            chk("rst_rf_wdata",  wb.rf_wdata,       32'd0);
            chk("rst_hazard",    32'(wb.hazard),    32'd0);
        end else begin
            bit force_alu, e_alu_rdy, e_lsu_rdy, e_hz, lsu_go, alu_go;
            force_alu = GUARD && (stalled_run >= SMAX) && wb.alu_valid;
            e_lsu_rdy = !force_alu;
            e_alu_rdy = !wb.lsu_valid || force_alu;
            e_hz      = pend.exists(int'(wb.rs0)) || pend.exists(int'(wb.rs1));

            chk("mdl_alu_ready", 32'(wb.alu_ready), 32'(e_alu_rdy));
            chk("mdl_lsu_ready", 32'(wb.lsu_ready), 32'(e_lsu_rdy));
            chk("mdl_hazard",    32'(wb.hazard),    32'(e_hz));
            chk("mdl_rf_we",     32'(wb.rf_we),     32'(m_we));
            chk("mdl_rf_waddr",  32'(wb.rf_waddr),  32'(m_waddr));
            chk("mdl_rf_wdata",  wb.rf_wdata,       m_wdata);

            lsu_go = wb.lsu_valid && e_lsu_rdy;
            alu_go = wb.alu_valid && e_alu_rdy && !lsu_go;

            m_we = 1'b0;
            if (lsu_go) begin
                m_we = (wb.lsu_rd != 0); m_waddr = wb.lsu_rd; m_wdata = wb.lsu_data;
                pend.delete(int'(wb.lsu_rd));
            end else if (alu_go) begin
                m_we = (wb.alu_rd != 0); m_waddr = wb.alu_rd; m_wdata = wb.alu_data;
            end
            if (wb.lsu_reserve && wb.lsu_reserve_rd != 0) begin
                pend[int'(wb.lsu_reserve_rd)] = 1'b1;
            end
            if (wb.alu_valid && !e_alu_rdy) begin
                stalled_run = (stalled_run < SMAX) ? stalled_run + 1 : SMAX;
            end else begin
                stalled_run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit a_acc, l_acc;

    initial begin
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
        wb.lsu_reserve = 1'b0; wb.lsu_reserve_rd = '0;
        wb.rs0 = '0; wb.rs1 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(wb.rf_we), 32'd0);
        step();
        rst = 1'b1;

        // ALU alone: accepted, written next cycle.
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
        #1;
        chk("t1_alu_ready", 32'(wb.alu_ready), 32'd1);
        step();
        wb.alu_valid = 1'b0;
        chk("t1_rf_we",     32'(wb.rf_we),    32'd1);
        chk("t1_rf_waddr",  32'(wb.rf_waddr), 32'd5);
        chk("t1_rf_wdata",  wb.rf_wdata,      32'hDEADBEEF);

        // Simultaneous requests: LSU first, ALU next cycle.
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h3333_0003;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'h7777_0007;
        #1;
        chk("t2_lsu_ready", 32'(wb.lsu_ready), 32'd1);
        chk("t2_alu_wait",  32'(wb.alu_ready), 32'd0);
        step();
        wb.lsu_valid = 1'b0;
        #1;
        chk("t2_rf_waddr_lsu", 32'(wb.rf_waddr), 32'd7);
        chk("t2_rf_wdata_lsu", wb.rf_wdata,      32'h7777_0007);
        chk("t2_alu_ready",    32'(wb.alu_ready), 32'd1);
        step();
        wb.alu_valid = 1'b0;
        chk("t2_rf_we_alu",    32'(wb.rf_we),    32'd1);
        chk("t2_rf_waddr_alu", 32'(wb.rf_waddr), 32'd3);

        // Continuous LSU traffic against a waiting ALU.
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd4; wb.alu_data = 32'h44;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd8; wb.lsu_data = 32'h88;
        #1;
`ifdef REGFILE_STARVE_GUARD_EN
        for (int i = 0; i < 3; i++) begin
            chk("t3_alu_stall", 32'(wb.alu_ready), 32'd0);
            step();
            #1;
        end
        chk("t3_alu_forced", 32'(wb.alu_ready), 32'd1);
        chk("t3_lsu_held",   32'(wb.lsu_ready), 32'd0);
        step();
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
        chk("t3_rf_waddr", 32'(wb.rf_waddr), 32'd4);
`else
        for (int i = 0; i < 6; i++) begin
            chk("t3_alu_starved", 32'(wb.alu_ready), 32'd0);
            step();
            #1;
        end
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
`endif
        step();

        // Scoreboard set / clear / same-cycle collision.
        wb.lsu_reserve = 1'b1; wb.lsu_reserve_rd = 5'd9; wb.rs0 = 5'd9; wb.rs1 = 5'd0;
        #1;
        chk("t4_hazard_before", 32'(wb.hazard), 32'd0);
        step();
        wb.lsu_reserve = 1'b0;
        #1;
        chk("t4_hazard_set", 32'(wb.hazard), 32'd1);
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd9; wb.lsu_data = 32'h99;
        #1;
        chk("t4_hazard_xfer_cycle", 32'(wb.hazard), 32'd1);
        step();
        wb.lsu_valid = 1'b0;
        #1;
        chk("t4_hazard_cleared", 32'(wb.hazard), 32'd0);
        wb.lsu_reserve = 1'b1; wb.lsu_reserve_rd = 5'd9;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd9; wb.lsu_data = 32'h999;
        step();
        wb.lsu_reserve = 1'b0; wb.lsu_valid = 1'b0;
        wb.rs0 = 5'd0; wb.rs1 = 5'd9;
        #1;
        chk("t4_set_wins", 32'(wb.hazard), 32'd1);
        wb.lsu_valid = 1'b1;
        step();
        wb.lsu_valid = 1'b0;
        #1;
        chk("t4_rs1_cleared", 32'(wb.hazard), 32'd0);

        // x0 handling.
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1234_5678;
        #1;
        chk("t5_alu_ready_x0", 32'(wb.alu_ready), 32'd1);
        step();
        wb.alu_valid = 1'b0;
        chk("t5_rf_we_x0", 32'(wb.rf_we), 32'd0);
        wb.lsu_reserve = 1'b1; wb.lsu_reserve_rd = 5'd0; wb.rs0 = 5'd0; wb.rs1 = 5'd0;
        step();
        wb.lsu_reserve = 1'b0;
        #1;
        chk("t5_hazard_x0", 32'(wb.hazard), 32'd0);

        // Asynchronous reset with a write in flight and a pending load.
        wb.lsu_reserve = 1'b1; wb.lsu_reserve_rd = 5'd9; wb.rs0 = 5'd9;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd12; wb.alu_data = 32'hCAFE_F00D;
        step();
        wb.lsu_reserve = 1'b0; wb.alu_valid = 1'b0;
        #1;
        chk("t6_pre_rf_we",  32'(wb.rf_we),  32'd1);
        chk("t6_pre_hazard", 32'(wb.hazard), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rf_we",     32'(wb.rf_we),    32'd0);
        chk("t6_rf_waddr",  32'(wb.rf_waddr), 32'd0);
        chk("t6_rf_wdata",  wb.rf_wdata,      32'd0);
        chk("t6_hazard",    32'(wb.hazard),   32'd0);
        step();
        step();
        rst = 1'b1;

        // Random traffic; requesters hold their request until it is taken.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            a_acc = wb.alu_valid && wb.alu_ready;
            l_acc = wb.lsu_valid && wb.lsu_ready;
            @(posedge clk);
            #1;
            if (!wb.alu_valid || a_acc) begin
                wb.alu_valid = ($urandom_range(0, 99) < 55);
                wb.alu_rd    = 5'($urandom_range(0, 15));
                wb.alu_data  = $urandom;
            end
            if (!wb.lsu_valid || l_acc) begin
                wb.lsu_valid = ($urandom_range(0, 99) < 60);
                wb.lsu_rd    = 5'($urandom_range(0, 15));
                wb.lsu_data  = $urandom;
            end
            wb.lsu_reserve    = ($urandom_range(0, 99) < 30);
            wb.lsu_reserve_rd = 5'($urandom_range(0, 15));
            wb.rs0            = 5'($urandom_range(0, 15));
            wb.rs1            = 5'($urandom_range(0, 15));
        end

        step();
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0; wb.lsu_reserve = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
